// File: rtl/secure_apb_gate.sv
// APB gate: routes one-hot upstream selects to downstream targets, blocks protected
// targets while locked, and owns a password/status register with fail counting and lockout.
module secure_apb_gate #(
    parameter int                   NUM_TGT     = 2,
    parameter int                   ADDR_W      = 20,
    parameter int                   DATA_W      = 16,
    parameter logic [NUM_TGT-1:0]   PROT_MASK   = 2'b10,
    parameter int                   PW_TGT      = 1,
    parameter logic [ADDR_W-1:0]    PW_ADDR     = 20'h00C1A,
    parameter logic [DATA_W-1:0]    PW_VALUE    = 16'hA007,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   LOCKOUT_CYC = 64,
    parameter int                   TIMEOUT_CYC = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_TGT-1:0]          psel_s,
    input  logic                        penable_s,
    input  logic                        pwrite_s,
    input  logic [DATA_W/8-1:0]         pstrb_s,
    input  logic [ADDR_W-1:0]           paddr_s,
    input  logic [DATA_W-1:0]           pwdata_s,
    output logic [DATA_W-1:0]           prdata_s,
    output logic                        pready_s,
    output logic                        pslverr_s,
    output logic [NUM_TGT-1:0]          psel_m,
    output logic                        penable_m,
    output logic                        pwrite_m,
    output logic [DATA_W/8-1:0]         pstrb_m,
    output logic [ADDR_W-1:0]           paddr_m,
    output logic [DATA_W-1:0]           pwdata_m,
    input  logic [NUM_TGT*DATA_W-1:0]   prdata_m,
    input  logic [NUM_TGT-1:0]          pready_m,
    input  logic [NUM_TGT-1:0]          pslverr_m,
    output logic                        locked_o,
    output logic                        lockout_o,
    output logic [1:0]                  fail_cnt_o
);
    localparam int SW = DATA_W / 8;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FWD_SETUP, S_FWD_ACCESS, S_LOCAL, S_RESP} state_t;
    typedef enum logic [1:0] {K_ERR, K_PW, K_FWD} kind_t;

    typedef struct packed {
        logic              write;
        logic [SW-1:0]     strb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t             state;
    kind_t              kind;
    req_t               req_q;
    logic [NUM_TGT-1:0] sel_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic               abort_q;
    logic [TW-1:0]      tcnt;
    logic [LW-1:0]      lk_cnt;

    logic               up_sel, up_act, is_pw, prot_hit, sel_rdy, sel_err, pw_ok, pw_wr_done;
    logic [DATA_W-1:0]  sel_rdata, resp_rdata;
    logic               resp_err;

    assign up_sel   = |psel_s;
    assign up_act   = up_sel & penable_s;
    assign is_pw    = psel_s[PW_TGT] && (paddr_s == PW_ADDR);
    assign prot_hit = (|(psel_s & PROT_MASK)) && locked_o;
    assign sel_rdy  = |(sel_q & pready_m);
    assign sel_err  = |(sel_q & pslverr_m);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++)
            if (sel_q[i]) sel_rdata = sel_rdata | prdata_m[i*DATA_W +: DATA_W];
    end

    // Password check uses lockout_o as seen in the RESP cycle, so an expiring lockout still rejects.
    assign pw_ok = (req_q.wdata == PW_VALUE) && (&req_q.strb) && !lockout_o;

    always_comb begin
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (kind == K_PW) begin
            if (req_q.write) begin
                resp_rdata = '0;
                resp_err   = !pw_ok;
            end else begin
                resp_rdata = DATA_W'({fail_cnt_o, lockout_o, locked_o});
                resp_err   = 1'b0;
            end
        end
    end

    assign pready_s   = (state == S_RESP) && up_act;
    assign prdata_s   = pready_s ? resp_rdata : '0;
    assign pslverr_s  = pready_s && resp_err;
    assign pw_wr_done = pready_s && (kind == K_PW) && req_q.write;

    assign pwrite_m = req_q.write;
    assign pstrb_m  = req_q.strb;
    assign paddr_m  = req_q.addr;
    assign pwdata_m = req_q.wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            kind      <= K_ERR;
            req_q     <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            tcnt      <= '0;
            psel_m    <= '0;
            penable_m <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (up_sel && !penable_s) begin
                    req_q   <= '{pwrite_s, pstrb_s, paddr_s, pwdata_s};
                    sel_q   <= psel_s;
                    abort_q <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    if (!$onehot(psel_s)) begin
                        kind  <= K_ERR;
                        state <= S_LOCAL;
                    end else if (is_pw) begin
                        kind  <= K_PW;
                        state <= S_LOCAL;
                    end else if (prot_hit) begin
                        kind  <= K_ERR;
                        state <= S_LOCAL;
                    end else begin
                        kind   <= K_FWD;
                        psel_m <= psel_s;
                        state  <= S_FWD_SETUP;
                    end
                end
                S_LOCAL: begin
                    if (!up_sel)        state <= S_IDLE;
                    else if (penable_s) state <= S_RESP;
                end
                S_FWD_SETUP: begin
                    penable_m <= 1'b1;
                    tcnt      <= '0;
                    if (!up_sel) abort_q <= 1'b1;
                    state     <= S_FWD_ACCESS;
                end
                S_FWD_ACCESS: begin
                    if (!up_sel) abort_q <= 1'b1;
                    // A dropped upstream select still lets the downstream transfer finish.
                    if (sel_rdy || tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        rdata_q   <= sel_rdy ? sel_rdata : '0;
                        err_q     <= sel_rdy ? sel_err : 1'b1;
                        psel_m    <= '0;
                        penable_m <= 1'b0;
                        state     <= (abort_q || !up_sel) ? S_IDLE : S_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_o   <= 1'b1;
            lockout_o  <= 1'b0;
            fail_cnt_o <= '0;
            lk_cnt     <= '0;
        end else begin
            if (lockout_o) begin
                if (lk_cnt == '0) begin
                    lockout_o  <= 1'b0;
                    fail_cnt_o <= '0;
                end else begin
                    lk_cnt <= lk_cnt - 1'b1;
                end
            end
            if (pw_wr_done) begin
                if (pw_ok) begin
                    locked_o   <= !locked_o;
                    fail_cnt_o <= '0;
                end else if (!lockout_o && fail_cnt_o != 2'(MAX_FAIL)) begin
                    fail_cnt_o <= fail_cnt_o + 2'd1;
                    if (fail_cnt_o == 2'(MAX_FAIL - 1)) begin
                        lockout_o <= 1'b1;
                        lk_cnt    <= LW'(LOCKOUT_CYC - 1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_secure_apb_gate.sv
// Randomized bench for secure_apb_gate: transaction-level reference model of routing,
// protection, password/lockout rules and timeouts, plus simple downstream target models.
module tb_secure_apb_gate;
    localparam int              NT = 2, AW = 20, DW = 16, SW = DW / 8;
    localparam int              PW_TGT = 1, MAX_FAIL = 3, LOCKOUT_CYC = 64, TIMEOUT_CYC = 16;
    localparam logic [NT-1:0]   PROT = 2'b10;
    localparam logic [AW-1:0]   PW_ADDR = 20'h00C1A;
    localparam logic [DW-1:0]   PW_VALUE = 16'hA007;

    logic clk, reset_n;
    logic [NT-1:0] psel_s, psel_m, pready_m, pslverr_m;
    logic penable_s, pwrite_s, pready_s, pslverr_s, penable_m, pwrite_m;
    logic [SW-1:0] pstrb_s, pstrb_m;
    logic [AW-1:0] paddr_s, paddr_m;
    logic [DW-1:0] pwdata_s, prdata_s, pwdata_m;
    logic [NT*DW-1:0] prdata_m;
    logic locked_o, lockout_o;
    logic [1:0] fail_cnt_o;

    secure_apb_gate dut (
        .clk(clk), .reset_n(reset_n),
        .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s), .pstrb_s(pstrb_s),
        .paddr_s(paddr_s), .pwdata_s(pwdata_s), .prdata_s(prdata_s), .pready_s(pready_s),
        .pslverr_s(pslverr_s), .psel_m(psel_m), .penable_m(penable_m), .pwrite_m(pwrite_m),
        .pstrb_m(pstrb_m), .paddr_m(paddr_m), .pwdata_m(pwdata_m), .prdata_m(prdata_m),
        .pready_m(pready_m), .pslverr_m(pslverr_m), .locked_o(locked_o),
        .lockout_o(lockout_o), .fail_cnt_o(fail_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream targets: ready after tgt_lat access cycles.
    int                   tgt_lat [NT];
    int                   acc_cnt [NT];
    logic [NT-1:0][DW-1:0] tgt_rd;
    logic [NT-1:0]        tgt_err;
    int                   setup_cnt [NT];
    logic [AW-1:0]        mon_addr;
    logic [DW-1:0]        mon_wdata;

    for (genvar g = 0; g < NT; g++) begin : g_tgt
        assign pready_m[g] = psel_m[g] & penable_m & (acc_cnt[g] == tgt_lat[g]);
    end
    assign pslverr_m = tgt_err;
    assign prdata_m  = tgt_rd;

    always @(posedge clk)
        for (int i = 0; i < NT; i++)
            acc_cnt[i] <= (psel_m[i] & penable_m & !pready_m[i]) ? acc_cnt[i] + 1 : 0;

    always @(negedge clk)
        for (int i = 0; i < NT; i++)
            if (psel_m[i] && !penable_m) begin
                setup_cnt[i] <= setup_cnt[i] + 1;
                mon_addr     <= paddr_m;
                mon_wdata    <= pwdata_m;
            end

    // Reference model of the lock state; lockout is a window of absolute cycle numbers.
    logic m_locked = 1'b1;
    int   m_fail = 0;
    logic m_lk = 1'b0;
    int   m_lk_until = 0;

    function automatic void m_tick();
        if (m_lk && cyc > m_lk_until) begin
            m_lk   = 1'b0;
            m_fail = 0;
        end
    endfunction

    function automatic int tot_setups();
        int t = 0;
        for (int i = 0; i < NT; i++) t += setup_cnt[i];
        return t;
    endfunction

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [NT-1:0] sel, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] strb, input string tag);
        int n, ti, s0, e_wait;
        logic got, g_err, e_err, e_fwd;
        logic [DW-1:0] g_rd, e_rd;
        logic [1:0] f2;
        ti = 0;
        for (int i = 0; i < NT; i++) if (sel[i]) ti = i;
        s0 = tot_setups();
        @(posedge clk); #1;
        psel_s = sel; penable_s = 1'b0; pwrite_s = wr; paddr_s = addr; pwdata_s = wd; pstrb_s = strb;
        @(posedge clk); #1;
        penable_s = 1'b1;
        n = 0; got = 1'b0; g_rd = '0; g_err = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (pready_s) begin
                got = 1'b1; g_rd = prdata_s; g_err = pslverr_s;
            end
        end
        m_tick();
        e_fwd = 1'b0; e_wait = 2; e_rd = '0; e_err = 1'b1;
        if (!$onehot(sel)) begin
            e_err = 1'b1;
        end else if (sel[PW_TGT] && addr == PW_ADDR) begin
            if (!wr) begin
                f2 = m_fail[1:0];
                e_rd = DW'({f2, m_lk, m_locked});
                e_err = 1'b0;
            end else if (wd == PW_VALUE && strb == '1 && !m_lk) begin
                m_locked = !m_locked; m_fail = 0; e_err = 1'b0;
            end else begin
                e_err = 1'b1;
                if (!m_lk) begin
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_lk = 1'b1; m_lk_until = cyc + LOCKOUT_CYC;
                    end
                end
            end
        end else if (PROT[ti] && m_locked) begin
            e_err = 1'b1;
        end else begin
            e_fwd = 1'b1;
            if (tgt_lat[ti] < TIMEOUT_CYC) begin
                e_wait = tgt_lat[ti] + 3; e_rd = tgt_rd[ti]; e_err = tgt_err[ti];
            end else begin
                e_wait = TIMEOUT_CYC + 2; e_rd = '0; e_err = 1'b1;
            end
        end
        chk({tag, "/ready"}, 32'(got), 32'd1);
        chk({tag, "/latency"}, n, e_wait);
        chk({tag, "/prdata"}, 32'(g_rd), 32'(e_rd));
        chk({tag, "/pslverr"}, 32'(g_err), 32'(e_err));
        chk({tag, "/fwd"}, tot_setups() - s0, 32'(e_fwd));
        if (e_fwd) begin
            chk({tag, "/paddr_m"}, 32'(mon_addr), 32'(addr));
            chk({tag, "/pwdata_m"}, 32'(mon_wdata), 32'(wd));
        end
        @(posedge clk); #1;
        psel_s = '0; penable_s = 1'b0;
        @(negedge clk);
        m_tick();
        chk({tag, "/locked"}, 32'(locked_o), 32'(m_locked));
        chk({tag, "/lockout"}, 32'(lockout_o), 32'(m_lk));
        chk({tag, "/fail_cnt"}, 32'(fail_cnt_o), m_fail);
    endtask

    initial begin
        int s0, rdy_seen, r;
        logic [NT-1:0] sel;
        reset_n = 1'b0; psel_s = '0; penable_s = 1'b0; pwrite_s = 1'b0;
        pstrb_s = '0; paddr_s = '0; pwdata_s = '0;
        tgt_rd = '0; tgt_err = '0;
        for (int i = 0; i < NT; i++) begin tgt_lat[i] = 0; acc_cnt[i] = 0; setup_cnt[i] = 0; end
        repeat (3) @(negedge clk);
        chk("rst/locked", 32'(locked_o), 32'd1);
        chk("rst/lockout", 32'(lockout_o), 32'd0);
        chk("rst/fail_cnt", 32'(fail_cnt_o), 32'd0);
        chk("rst/pready_s", 32'(pready_s), 32'd0);
        chk("rst/psel_m", 32'(psel_m), 32'd0);
        chk("rst/penable_m", 32'(penable_m), 32'd0);
        chk("rst/paddr_m", 32'(paddr_m), 32'd0);
        reset_n = 1'b1;

        // Directed scenarios
        tgt_lat[0] = 5; tgt_rd[0] = 16'h5A5A;
        xfer(2'b01, 1'b1, 20'h00123, 16'h9432, 2'b11, "t1_fwd_locked");
        xfer(2'b10, 1'b1, 20'h0B00A, 16'h1111, 2'b11, "t2_prot_blocked");
        xfer(2'b10, 1'b1, PW_ADDR, PW_VALUE, 2'b11, "t3_unlock");
        chk("t3/unlocked", 32'(locked_o), 32'd0);
        tgt_lat[1] = 2; tgt_rd[1] = 16'h0E33;
        xfer(2'b10, 1'b0, 20'h00111, 16'h0, 2'b11, "t3_rd_tgt1");
        xfer(2'b10, 1'b1, PW_ADDR, PW_VALUE, 2'b11, "t4_relock");
        xfer(2'b10, 1'b0, 20'h00111, 16'h0, 2'b11, "t4_rd_blocked");
        xfer(2'b10, 1'b0, PW_ADDR, 16'h0, 2'b11, "t4_status_rd");
        for (int k = 0; k < MAX_FAIL; k++) xfer(2'b10, 1'b1, PW_ADDR, 16'h1234, 2'b11, "t5_bad_pw");
        chk("t5/lockout", 32'(lockout_o), 32'd1);
        chk("t5/fail_cnt", 32'(fail_cnt_o), 32'(MAX_FAIL));
        xfer(2'b10, 1'b1, PW_ADDR, PW_VALUE, 2'b11, "t5_pw_in_lockout");
        xfer(2'b10, 1'b1, PW_ADDR, PW_VALUE, 2'b01, "t5_partial_strb");
        while (cyc <= m_lk_until) @(negedge clk);
        xfer(2'b10, 1'b1, PW_ADDR, PW_VALUE, 2'b11, "t5_pw_after_expiry");
        xfer(2'b11, 1'b0, 20'h00020, 16'h0, 2'b11, "bad_onehot");

        // Upstream abort of a forwarded transfer: downstream finishes, no upstream response
        tgt_lat[0] = 4;
        s0 = tot_setups(); rdy_seen = 0;
        @(posedge clk); #1; psel_s = 2'b01; pwrite_s = 1'b0; paddr_s = 20'h00044;
        @(posedge clk); #1; penable_s = 1'b1;
        @(posedge clk); #1; psel_s = '0; penable_s = 1'b0;
        repeat (12) begin @(negedge clk); if (pready_s) rdy_seen++; end
        chk("abort/no_ready", rdy_seen, 0);
        chk("abort/fwd_started", tot_setups() - s0, 1);
        chk("abort/psel_m_idle", 32'(psel_m), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 6);
            sel = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            for (int i = 0; i < NT; i++) begin
                tgt_lat[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT_CYC + 1 : $urandom_range(0, 6);
                tgt_rd[i]  = DW'($urandom);
                tgt_err[i] = ($urandom_range(0, 3) == 0);
            end
            xfer(sel, 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? PW_ADDR : AW'($urandom),
                 ($urandom_range(0, 2) == 0) ? PW_VALUE : DW'($urandom),
                 ($urandom_range(0, 3) == 0) ? SW'($urandom) : {SW{1'b1}}, "rnd");
        end

        // Target that never answers: forced timeout
        tgt_lat[0] = 1000; tgt_err = '0;
        xfer(2'b01, 1'b0, 20'h00300, 16'h0, 2'b11, "t6_timeout");

        // Reset in the middle of a downstream access
        @(posedge clk); #1; psel_s = 2'b01; pwrite_s = 1'b1; paddr_s = 20'h00301;
        @(posedge clk); #1; penable_s = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6/in_access", 32'(penable_m), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6/rst_psel_m", 32'(psel_m), 32'd0);
        chk("t6/rst_penable_m", 32'(penable_m), 32'd0);
        chk("t6/rst_locked", 32'(locked_o), 32'd1);
        chk("t6/rst_pready_s", 32'(pready_s), 32'd0);
        psel_s = '0; penable_s = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
